axis_frame_packer: RTL
======================

# axis_frame_packer

Upstream feeder for the windowing stage of the FFT core. The block takes a one-sample-per-beat AXI-Stream from the ADC/DDC side and packs BUS_NUM consecutive samples into one wide beat. It asserts tlast every FFT_SIZE samples and re-aligns frames when the source's tlast disagrees with the frame length. Its output drives the window function's in_tvalid/in_tready/in_tlast/in_tdata[BUS_NUM] directly.

## Interface
- FFT_SIZE, 8192: samples per frame; power of 2, >= 2*BUS_NUM.
- BUS_NUM, 2: lanes per output beat; power of 2, >= 2.
- BEAT_AW, $clog2(FFT_SIZE/BUS_NUM): beat-counter width.
- FCNT_W, 16: frame-counter width.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_tvalid  in  1  AXIS input valid.
- in_tready  out  1  AXIS input ready.
- in_tlast  in  1  source end-of-frame marker.
- in_tdata  in  sample_t_int  one complex sample.
- out_tvalid  out  1  AXIS output valid.
- out_tready  in  1  AXIS output ready.
- out_tlast  out  1  last beat of frame (beat FFT_SIZE/BUS_NUM-1).
- out_tdata  out  sample_t_int [BUS_NUM]  packed samples; lane 0 = earliest.
- frame_cnt  out  FCNT_W  frames emitted; wraps.
- short_err  out  1  one-cycle pulse: in_tlast arrived before sample FFT_SIZE-1.
- long_err  out  1  one-cycle pulse: sample FFT_SIZE-1 accepted without in_tlast.

## Operation
- Counters: lane_cnt (log2 BUS_NUM bits) and beat_cnt (BEAT_AW bits). Both wrap to 0 after a frame.
- FSM has two states, FILL and PAD.
- FILL:
  - Each input handshake writes in_tdata into lane lane_cnt.
  - Lanes 0..BUS_NUM-2 go to an assembly register.
  - The sample on lane BUS_NUM-1 is loaded, together with the assembly lanes, into the output register. out_tlast = (beat_cnt == last).
  - in_tready = !rst & ((lane_cnt != BUS_NUM-1) | !out_tvalid | out_tready). The combinational path out_tready -> in_tready is permitted.
- Early in_tlast: handshake with in_tlast=1 at any sample other than FFT_SIZE-1.
  - Pulse short_err the next cycle; go to PAD.
  - If it was lane BUS_NUM-1, that beat is emitted normally, with no tlast.
- PAD:
  - in_tready = 0.
  - On each cycle where the output register is free, emit a beat: already-collected lanes are kept, remaining lanes are {0,0}.
  - Subsequent beats are all-zero until the beat with beat_cnt = last, which carries out_tlast = 1. Then return to FILL with counters at 0.
- Late/missing in_tlast: sample FFT_SIZE-1 accepted with in_tlast=0.
  - Frame closes normally with out_tlast; long_err pulses.
  - The next input sample starts a new frame.
- frame_cnt increments on each output handshake with out_tlast=1.
- Output register holds out_tdata/out_tlast stable while out_tvalid & !out_tready (AXIS rule).

## Timing
- Reset values: out_tvalid=0, out_tlast=0, out_tdata all {0,0}, frame_cnt=0, short_err=0, long_err=0, in_tready=0 while rst=1. State=FILL, counters 0.
- Latency: out_tvalid rises 1 cycle after the handshake of lane BUS_NUM-1.
- Throughput: one input sample per cycle sustained while out_tready=1. Output valid duty = 1/BUS_NUM.
- Simultaneous out_tready & final-lane input handshake: old beat leaves and new beat loads in the same cycle, with no bubble.
- PAD with out_tready=1 emits one beat per cycle.
- Error pulses are registered: asserted the cycle after the offending handshake.
- rst asserted mid-frame or mid-PAD: everything returns to reset values on the next edge. Partial beats are discarded and nothing is emitted.

## Structure
- axis_pkg already holds sample_t_int (re, im: 16-bit signed each). No new typedefs are needed.
- Add the localparam frame-error encoding to axis_pkg only if the status later moves to APB; for now, pulses only.
- No sub-module is needed. Assembly register, output register, counters and the 2-state FSM live in one module.

## Test plan
- FFT_SIZE=16, BUS_NUM=2; stream re=0..15, in_tlast on 15, out_tready=1 -> 8 beats {0,1},{2,3}..{14,15}; tlast only on beat 7; frame_cnt=1; no error pulses.
- Same stream, out_tready toggling 1/0 each cycle -> identical beat sequence; in_tready low only when lane 1 is pending and output is stalled; no sample lost or duplicated.
- in_tlast on sample 4 (re=4) -> short_err pulse; beats {0,1},{2,3},{4,0},{0,0}x4,{0,0}+tlast; in_tready=0 throughout PAD.
- 20 samples with no in_tlast -> long_err pulse one cycle after sample 15; beat 7 has tlast; samples 16..19 form beats {16,17},{18,19} of frame 2.
- rst pulsed after 5 samples -> outputs at reset values; next 16 samples form a clean frame starting at lane 0.
- 4 back-to-back correct frames with random out_tready -> frame_cnt=4; tlast exactly every 8th output handshake.

Source files
------------

// File: rtl/axis_pkg.sv
// ----------------------------------------------------------------------------
// axis_pkg
// Shared AXI-Stream sample types for the FFT front end.
//   sample_t_int : one complex sample, 16-bit signed real and imaginary parts.
// ----------------------------------------------------------------------------
package axis_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } sample_t_int;

endpackage

// File: rtl/axis_frame_packer.sv
// ----------------------------------------------------------------------------
// axis_frame_packer
// Packs BUS_NUM consecutive one-sample AXI-Stream beats into one wide beat and
// marks the last beat of every FFT_SIZE-sample frame with out_tlast. A source
// tlast that arrives early closes the frame with zero padding (short_err);
// a missing source tlast at the frame boundary is flagged (long_err).
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   in_tvalid     : input sample valid
//   in_tready     : input ready (combinational from out_tready)
//   in_tlast      : source end-of-frame marker
//   in_tdata      : one complex sample
//   out_tvalid    : packed beat valid
//   out_tready    : downstream ready
//   out_tlast     : last beat of the frame
//   out_tdata     : BUS_NUM samples, lane 0 = earliest
//   frame_cnt     : frames emitted (wraps)
//   short_err     : one-cycle pulse, in_tlast before the frame's last sample
//   long_err      : one-cycle pulse, frame's last sample without in_tlast
// ----------------------------------------------------------------------------
module axis_frame_packer
    import axis_pkg::*;
#(
    parameter int FFT_SIZE = 8192,
    parameter int BUS_NUM  = 2,
    parameter int BEAT_AW  = $clog2(FFT_SIZE / BUS_NUM),
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_tvalid,
    output logic              in_tready,
    input  logic              in_tlast,
    input  sample_t_int       in_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              out_tlast,
    output sample_t_int       out_tdata [BUS_NUM],
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              short_err,
    output logic              long_err
);

    localparam int                 LANE_W    = $clog2(BUS_NUM);
    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(BUS_NUM - 1);
    localparam logic [BEAT_AW-1:0] LAST_BEAT = BEAT_AW'(FFT_SIZE / BUS_NUM - 1);
    localparam sample_t_int        ZERO_SMP  = sample_t_int'(32'd0);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [LANE_W-1:0]   lane_cnt_r;
    logic [LANE_W-1:0]   lane_nxt_s;
    logic [BEAT_AW-1:0]  beat_cnt_r;
    logic [BEAT_AW-1:0]  beat_nxt_s;
    sample_t_int         asm_r [BUS_NUM-1];
    sample_t_int         out_data_r [BUS_NUM];
    sample_t_int         load_data_s [BUS_NUM];
    logic                out_valid_r;
    logic                out_last_r;
    logic [FCNT_W-1:0]   frame_cnt_r;
    logic                short_err_r;
    logic                long_err_r;

    logic                free_s;
    logic                in_ready_s;
    logic                in_hs_s;
    logic                last_lane_s;
    logic                last_beat_s;
    logic                frame_end_s;
    logic                load_s;
    logic                load_last_s;
    logic                short_nxt_s;
    logic                long_nxt_s;

    // Output register can take a new beat when empty or draining this cycle.
    assign free_s      = !out_valid_r || out_tready;
    assign last_lane_s = (lane_cnt_r == LAST_LANE);
    assign last_beat_s = (beat_cnt_r == LAST_BEAT);
    assign frame_end_s = last_lane_s && last_beat_s;

    // Only the final lane needs room in the output register; earlier lanes
    // land in the assembly register and never stall.
    assign in_ready_s = (state_r == FILL) && (!last_lane_s || free_s);
    assign in_tready  = !rst && in_ready_s;
    assign in_hs_s    = in_tvalid && in_tready;

    assign out_tvalid = out_valid_r;
    assign out_tlast  = out_last_r;
    assign out_tdata  = out_data_r;
    assign frame_cnt  = frame_cnt_r;
    assign short_err  = short_err_r;
    assign long_err   = long_err_r;

    // Next-state, counter and output-load decode for the FILL/PAD machine.
    always_comb begin
        state_nxt_s = state_r;
        lane_nxt_s  = lane_cnt_r;
        beat_nxt_s  = beat_cnt_r;
        load_s      = 1'b0;
        load_last_s = 1'b0;
        short_nxt_s = 1'b0;
        long_nxt_s  = 1'b0;
        for (int i = 0; i < BUS_NUM; i++) begin
            load_data_s[i] = ZERO_SMP;
        end

        case (state_r)
            FILL: begin
                for (int i = 0; i < BUS_NUM - 1; i++) begin
                    load_data_s[i] = asm_r[i];
                end
                load_data_s[BUS_NUM-1] = in_tdata;
                if (in_hs_s) begin
                    if (last_lane_s) begin
                        load_s      = 1'b1;
                        load_last_s = last_beat_s;
                        lane_nxt_s  = {LANE_W{1'b0}};
                        if (last_beat_s) begin
                            beat_nxt_s = {BEAT_AW{1'b0}};
                        end else begin
                            beat_nxt_s = beat_cnt_r + BEAT_AW'(1);
                        end
                    end else begin
                        lane_nxt_s = lane_cnt_r + LANE_W'(1);
                    end
                    // Early source tlast: the remaining frame is padded.
                    if (in_tlast && !frame_end_s) begin
                        short_nxt_s = 1'b1;
                        state_nxt_s = PAD;
                    end else if (!in_tlast && frame_end_s) begin
                        long_nxt_s = 1'b1;
                    end else begin
                        short_nxt_s = 1'b0;
                    end
                end else begin
                    lane_nxt_s = lane_cnt_r;
                end
            end

            PAD: begin
                // Lanes below lane_cnt were collected before the early tlast.
                for (int i = 0; i < BUS_NUM - 1; i++) begin
                    if (LANE_W'(i) < lane_cnt_r) begin
                        load_data_s[i] = asm_r[i];
                    end else begin
                        load_data_s[i] = ZERO_SMP;
                    end
                end
                if (free_s) begin
                    load_s      = 1'b1;
                    load_last_s = last_beat_s;
                    lane_nxt_s  = {LANE_W{1'b0}};
                    if (last_beat_s) begin
                        beat_nxt_s  = {BEAT_AW{1'b0}};
                        state_nxt_s = FILL;
                    end else begin
                        beat_nxt_s = beat_cnt_r + BEAT_AW'(1);
                    end
                end else begin
                    load_s = 1'b0;
                end
            end

            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // FSM state, lane/beat counters and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FILL;
            lane_cnt_r  <= {LANE_W{1'b0}};
            beat_cnt_r  <= {BEAT_AW{1'b0}};
            short_err_r <= 1'b0;
            long_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            lane_cnt_r  <= lane_nxt_s;
            beat_cnt_r  <= beat_nxt_s;
            short_err_r <= short_nxt_s;
            long_err_r  <= long_nxt_s;
        end
    end

    // Assembly register: holds lanes 0..BUS_NUM-2 of the beat being built.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUS_NUM - 1; i++) begin
                asm_r[i] <= ZERO_SMP;
            end
        end else begin
            for (int i = 0; i < BUS_NUM - 1; i++) begin
                if (in_hs_s && (lane_cnt_r == LANE_W'(i))) begin
                    asm_r[i] <= in_tdata;
                end
            end
        end
    end

    // Output register and frame counter; contents hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            frame_cnt_r <= {FCNT_W{1'b0}};
            for (int i = 0; i < BUS_NUM; i++) begin
                out_data_r[i] <= ZERO_SMP;
            end
        end else begin
            if (out_valid_r && out_tready && out_last_r) begin
                frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
            end
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= load_last_s;
                out_data_r  <= load_data_s;
            end else if (out_tready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule
